// File: rtl/acc_req_arbiter.sv
// Round-robin arbiter that shares one accelerator request/response port among
// NumReq offloading cores. Requests are registered and tagged with the master
// index in the upper ID bits; responses are routed back by those bits.
module acc_req_arbiter #(
   parameter int unsigned NumReq         = 8,
   parameter int unsigned AccAddrWidth   = 3,
   parameter int unsigned DataWidth      = 32,
   parameter int unsigned InIdWidth      = 5,
   parameter int unsigned MaxOutstanding = 4,
   parameter int unsigned IdxWidth       = (NumReq > 1) ? $clog2(NumReq) : 1,
   parameter int unsigned ExtIdWidth     = InIdWidth + IdxWidth
) (
   input  logic                                   clk_i,
   input  logic                                   rst_ni,
   input  logic [NumReq-1:0]                      mst_q_valid_i,
   output logic [NumReq-1:0]                      mst_q_ready_o,
   input  logic [NumReq-1:0][AccAddrWidth-1:0]    mst_q_addr_i,
   input  logic [NumReq-1:0][InIdWidth-1:0]       mst_q_id_i,
   input  logic [NumReq-1:0][DataWidth-1:0]       mst_q_data_i,
   output logic [NumReq-1:0]                      mst_p_valid_o,
   input  logic [NumReq-1:0]                      mst_p_ready_i,
   output logic [InIdWidth-1:0]                   mst_p_id_o,
   output logic [DataWidth-1:0]                   mst_p_data_o,
   output logic                                   slv_q_valid_o,
   input  logic                                   slv_q_ready_i,
   output logic [AccAddrWidth-1:0]                slv_q_addr_o,
   output logic [ExtIdWidth-1:0]                  slv_q_id_o,
   output logic [DataWidth-1:0]                   slv_q_data_o,
   input  logic                                   slv_p_valid_i,
   output logic                                   slv_p_ready_o,
   input  logic [ExtIdWidth-1:0]                  slv_p_id_i,
   input  logic [DataWidth-1:0]                   slv_p_data_i,
   output logic                                   rsp_err_o
);

   localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);

   logic [NumReq-1:0][CntWidth-1:0] cnt_q, cnt_d;
   logic [IdxWidth-1:0]             rr_ptr_q, rr_ptr_d;
   logic                            slv_q_valid_q, slv_q_valid_d;
   logic [AccAddrWidth-1:0]         slv_q_addr_q, slv_q_addr_d;
   logic [ExtIdWidth-1:0]           slv_q_id_q, slv_q_id_d;
   logic [DataWidth-1:0]            slv_q_data_q, slv_q_data_d;
   logic                            rsp_err_q, rsp_err_d;

   logic                load;
   logic [NumReq-1:0]   eligible;
   logic                gnt_valid;
   logic [IdxWidth-1:0] gnt_idx;
   logic [31:0]         ptr_ext, gnt_ext, rsp_idx_ext;
   logic [IdxWidth-1:0] rsp_idx;
   logic                rsp_hs, rsp_in_range;

   // Round-robin grant: first eligible master strictly after rr_ptr, with wrap.
   always_comb begin
      load      = !slv_q_valid_q || slv_q_ready_i;
      ptr_ext   = 32'(rr_ptr_q);
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      eligible  = '0;
      for (int unsigned k = 0; k < NumReq; k++) begin
         eligible[k] = mst_q_valid_i[k] && (cnt_q[k] < CntWidth'(MaxOutstanding));
      end
      // Two passes: masters above the pointer first, then the wrapped-around ones.
      for (int unsigned k = 0; k < NumReq; k++) begin
         if (!gnt_valid && eligible[k] && (k > ptr_ext)) begin
            gnt_valid = 1'b1;
            gnt_idx   = IdxWidth'(k);
         end
      end
      for (int unsigned k = 0; k < NumReq; k++) begin
         if (!gnt_valid && eligible[k] && (k <= ptr_ext)) begin
            gnt_valid = 1'b1;
            gnt_idx   = IdxWidth'(k);
         end
      end
      gnt_ext = 32'(gnt_idx);
      // Ready is held low while in reset so no request is accepted and then lost.
      mst_q_ready_o = '0;
      for (int unsigned k = 0; k < NumReq; k++) begin
         mst_q_ready_o[k] = rst_ni && load && gnt_valid && (gnt_ext == k);
      end
   end

   // Response demux by the index bits; out-of-range indices are swallowed.
   always_comb begin
      rsp_idx       = slv_p_id_i[ExtIdWidth-1 -: IdxWidth];
      rsp_idx_ext   = 32'(rsp_idx);
      rsp_in_range  = rsp_idx_ext < NumReq;
      mst_p_valid_o = '0;
      slv_p_ready_o = 1'b1;
      for (int unsigned k = 0; k < NumReq; k++) begin
         if (rsp_idx_ext == k) begin
            mst_p_valid_o[k] = slv_p_valid_i;
            slv_p_ready_o    = mst_p_ready_i[k];
         end
      end
      mst_p_id_o   = slv_p_id_i[InIdWidth-1:0];
      mst_p_data_o = slv_p_data_i;
      rsp_hs       = slv_p_valid_i && slv_p_ready_o;
   end

   // Next state: output register, round-robin pointer, counters, error flag.
   always_comb begin
      slv_q_valid_d = slv_q_valid_q;
      slv_q_addr_d  = slv_q_addr_q;
      slv_q_id_d    = slv_q_id_q;
      slv_q_data_d  = slv_q_data_q;
      rr_ptr_d      = rr_ptr_q;
      if (load) begin
         slv_q_valid_d = gnt_valid;
         if (gnt_valid) begin
            rr_ptr_d = gnt_idx;
            for (int unsigned k = 0; k < NumReq; k++) begin
               if (gnt_ext == k) begin
                  slv_q_addr_d = mst_q_addr_i[k];
                  slv_q_id_d   = {gnt_idx, mst_q_id_i[k]};
                  slv_q_data_d = mst_q_data_i[k];
               end
            end
         end
      end
      rsp_err_d = rsp_err_q || (rsp_hs && !rsp_in_range);
      cnt_d     = cnt_q;
      for (int unsigned k = 0; k < NumReq; k++) begin
         if (mst_q_ready_o[k] && !(rsp_hs && (rsp_idx_ext == k))) begin
            cnt_d[k] = cnt_q[k] + CntWidth'(1);
         end else if (!mst_q_ready_o[k] && rsp_hs && (rsp_idx_ext == k) &&
                      (cnt_q[k] != '0)) begin
            cnt_d[k] = cnt_q[k] - CntWidth'(1);
         end
         if (rsp_hs && (rsp_idx_ext == k) && (cnt_q[k] == '0)) begin
            rsp_err_d = 1'b1;
         end
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cnt_q         <= '0;
         rr_ptr_q      <= IdxWidth'(NumReq - 1);
         slv_q_valid_q <= 1'b0;
         slv_q_addr_q  <= '0;
         slv_q_id_q    <= '0;
         slv_q_data_q  <= '0;
         rsp_err_q     <= 1'b0;
      end else begin
         cnt_q         <= cnt_d;
         rr_ptr_q      <= rr_ptr_d;
         slv_q_valid_q <= slv_q_valid_d;
         slv_q_addr_q  <= slv_q_addr_d;
         slv_q_id_q    <= slv_q_id_d;
         slv_q_data_q  <= slv_q_data_d;
         rsp_err_q     <= rsp_err_d;
      end
   end

   assign slv_q_valid_o = slv_q_valid_q;
   assign slv_q_addr_o  = slv_q_addr_q;
   assign slv_q_id_o    = slv_q_id_q;
   assign slv_q_data_o  = slv_q_data_q;
   assign rsp_err_o     = rsp_err_q;

endmodule

// File: tb/tb_acc_req_arbiter.sv
// Directed bench for acc_req_arbiter: an 8-master instance for the main
// behaviour and a 5-master instance for out-of-range response indices.
module tb_acc_req_arbiter;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // 8-master instance
   logic [7:0]        q_valid, q_ready;
   logic [7:0][2:0]   q_addr;
   logic [7:0][4:0]   q_id;
   logic [7:0][31:0]  q_data;
   logic [7:0]        p_valid, p_ready;
   logic [4:0]        p_id;
   logic [31:0]       p_data;
   logic              slv_q_valid, slv_q_ready;
   logic [2:0]        slv_q_addr;
   logic [7:0]        slv_q_id;
   logic [31:0]       slv_q_data;
   logic              slv_p_valid, slv_p_ready;
   logic [7:0]        slv_p_id;
   logic [31:0]       slv_p_data;
   logic              rsp_err;

   // 5-master instance
   logic [4:0]        q_valid5, q_ready5;
   logic [4:0][2:0]   q_addr5;
   logic [4:0][4:0]   q_id5;
   logic [4:0][31:0]  q_data5;
   logic [4:0]        p_valid5, p_ready5;
   logic [4:0]        p_id5;
   logic [31:0]       p_data5;
   logic              slv_q_valid5, slv_q_ready5;
   logic [2:0]        slv_q_addr5;
   logic [7:0]        slv_q_id5;
   logic [31:0]       slv_q_data5;
   logic              slv_p_valid5, slv_p_ready5;
   logic [7:0]        slv_p_id5;
   logic [31:0]       slv_p_data5;
   logic              rsp_err5;

   acc_req_arbiter #(.NumReq(8), .AccAddrWidth(3), .DataWidth(32), .InIdWidth(5),
                     .MaxOutstanding(4)) u_dut (
      .clk_i(clk), .rst_ni(rst_n),
      .mst_q_valid_i(q_valid), .mst_q_ready_o(q_ready), .mst_q_addr_i(q_addr),
      .mst_q_id_i(q_id), .mst_q_data_i(q_data),
      .mst_p_valid_o(p_valid), .mst_p_ready_i(p_ready), .mst_p_id_o(p_id),
      .mst_p_data_o(p_data),
      .slv_q_valid_o(slv_q_valid), .slv_q_ready_i(slv_q_ready), .slv_q_addr_o(slv_q_addr),
      .slv_q_id_o(slv_q_id), .slv_q_data_o(slv_q_data),
      .slv_p_valid_i(slv_p_valid), .slv_p_ready_o(slv_p_ready), .slv_p_id_i(slv_p_id),
      .slv_p_data_i(slv_p_data), .rsp_err_o(rsp_err)
   );

   acc_req_arbiter #(.NumReq(5), .AccAddrWidth(3), .DataWidth(32), .InIdWidth(5),
                     .MaxOutstanding(4)) u_dut5 (
      .clk_i(clk), .rst_ni(rst_n),
      .mst_q_valid_i(q_valid5), .mst_q_ready_o(q_ready5), .mst_q_addr_i(q_addr5),
      .mst_q_id_i(q_id5), .mst_q_data_i(q_data5),
      .mst_p_valid_o(p_valid5), .mst_p_ready_i(p_ready5), .mst_p_id_o(p_id5),
      .mst_p_data_o(p_data5),
      .slv_q_valid_o(slv_q_valid5), .slv_q_ready_i(slv_q_ready5), .slv_q_addr_o(slv_q_addr5),
      .slv_q_id_o(slv_q_id5), .slv_q_data_o(slv_q_data5),
      .slv_p_valid_i(slv_p_valid5), .slv_p_ready_o(slv_p_ready5), .slv_p_id_i(slv_p_id5),
      .slv_p_data_i(slv_p_data5), .rsp_err_o(rsp_err5)
   );

   int nchk  = 0;
   int npass = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nchk++;
      assert (obs === exp) npass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst_n       = 1'b0;
      q_valid     = '0;
      p_ready     = '0;
      slv_q_ready = 1'b0;
      slv_p_valid = 1'b0;
      slv_p_id    = '0;
      slv_p_data  = '0;
      for (int k = 0; k < 8; k++) begin
         q_addr[k] = 3'(k);
         q_id[k]   = 5'(k);
         q_data[k] = 32'hA000_0000 + 32'(k);
      end
      q_valid5     = '0;
      q_addr5      = '0;
      q_id5        = '0;
      q_data5      = '0;
      p_ready5     = '0;
      slv_q_ready5 = 1'b0;
      slv_p_valid5 = 1'b0;
      slv_p_id5    = '0;
      slv_p_data5  = '0;

      // Reset state, with every master requesting
      q_valid = 8'hFF;
      tick();
      tick();
      chk("rst_ready", q_ready, 64'h00);
      chk("rst_slv_valid", slv_q_valid, 64'h0);
      chk("rst_slv_id", slv_q_id, 64'h0);
      chk("rst_slv_addr", slv_q_addr, 64'h0);
      chk("rst_slv_data", slv_q_data, 64'h0);
      chk("rst_p_valid", p_valid, 64'h0);
      chk("rst_err", rsp_err, 64'h0);
      chk("rst_err5", rsp_err5, 64'h0);

      // Round-robin order 0..7,0,1
      slv_q_ready = 1'b1;
      rst_n = 1'b1;
      #1;
      chk("rr_first_grant", q_ready, 64'h01);
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("rr_valid", slv_q_valid, 64'h1);
         chk("rr_ext_id", slv_q_id, 64'((i % 8) * 33));
         chk("rr_addr", slv_q_addr, 64'(i % 8));
         chk("rr_data", slv_q_data, 64'(32'hA000_0000 + 32'(i % 8)));
         chk("rr_next_ready", q_ready, 64'(1 << ((i + 1) % 8)));
      end

      // Reset mid-operation with requests held and counters non-zero
      rst_n = 1'b0;
      #1;
      chk("rst_mid_ready", q_ready, 64'h00);
      tick();
      chk("rst_mid_slv_valid", slv_q_valid, 64'h0);
      rst_n = 1'b1;
      #1;
      chk("rst_mid_first_grant", q_ready, 64'h01);
      q_valid = '0;
      // Late response for master 0 after reset: counter is 0, so error
      slv_p_valid = 1'b1;
      slv_p_id    = 8'h03;
      p_ready     = 8'h01;
      #1;
      chk("late_rsp_route", p_valid, 64'h01);
      chk("late_rsp_ready", slv_p_ready, 64'h1);
      tick();
      slv_p_valid = 1'b0;
      chk("late_rsp_err", rsp_err, 64'h1);
      chk("late_slv_idle", slv_q_valid, 64'h0);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      #1;
      chk("err_cleared", rsp_err, 64'h0);

      // Backpressure: master 3 held 5 cycles, master 1 waiting behind it
      p_ready     = '0;
      slv_q_ready = 1'b0;
      q_valid     = 8'h08;
      q_addr[3]   = 3'd2;
      q_data[3]   = 32'hDEAD_BEEF;
      q_id[3]     = 5'h0B;
      #1;
      chk("bp_grant_empty", q_ready, 64'h08);
      tick();
      q_valid = 8'h02;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("bp_ready_low", q_ready, 64'h00);
         chk("bp_valid", slv_q_valid, 64'h1);
         chk("bp_id", slv_q_id, 64'h6B);
         chk("bp_addr", slv_q_addr, 64'h2);
         chk("bp_data", slv_q_data, 64'hDEAD_BEEF);
         tick();
      end
      slv_q_ready = 1'b1;
      #1;
      chk("bp_drain_grant", q_ready, 64'h02);
      chk("bp_drain_data", slv_q_data, 64'hDEAD_BEEF);
      tick();
      chk("bp_next_id", slv_q_id, 64'h21);
      chk("bp_next_data", slv_q_data, 64'hA000_0001);
      q_valid = '0;
      tick();
      chk("bp_idle", slv_q_valid, 64'h0);

      // Outstanding cap on master 2
      q_valid = 8'h04;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("cap_grant", q_ready, 64'h04);
         tick();
      end
      #1;
      chk("cap_full_block", q_ready, 64'h00);
      tick();
      chk("cap_still_blocked", q_ready, 64'h00);
      chk("cap_drained", slv_q_valid, 64'h0);
      slv_p_valid = 1'b1;
      slv_p_id    = 8'h47;
      p_ready     = 8'h04;
      #1;
      chk("cap_rsp_route", p_valid, 64'h04);
      chk("cap_rsp_ready", slv_p_ready, 64'h1);
      chk("cap_same_cycle", q_ready, 64'h00);
      tick();
      slv_p_valid = 1'b0;
      p_ready     = '0;
      #1;
      chk("cap_regrant", q_ready, 64'h04);
      tick();
      chk("cap_fifth_valid", slv_q_valid, 64'h1);
      chk("cap_fifth_id", slv_q_id, 64'h42);
      q_valid = '0;
      chk("cap_no_err", rsp_err, 64'h0);

      // Response routing to master 5
      slv_p_valid = 1'b1;
      slv_p_id    = 8'hBA;
      slv_p_data  = 32'h0000_1234;
      p_ready     = 8'h00;
      #1;
      chk("route_valid", p_valid, 64'h20);
      chk("route_id", p_id, 64'h1A);
      chk("route_data", p_data, 64'h1234);
      chk("route_ready_none", slv_p_ready, 64'h0);
      p_ready = 8'hDF;
      #1;
      chk("route_ready_other", slv_p_ready, 64'h0);
      p_ready = 8'h20;
      #1;
      chk("route_ready_own", slv_p_ready, 64'h1);
      slv_p_valid = 1'b0;
      p_ready     = '0;
      #1;
      chk("route_no_valid", p_valid, 64'h00);
      tick();

      // Response to master 6 with nothing outstanding
      slv_p_valid = 1'b1;
      slv_p_id    = 8'hC1;
      p_ready     = 8'h40;
      #1;
      chk("err_pre", rsp_err, 64'h0);
      chk("err_ready", slv_p_ready, 64'h1);
      tick();
      slv_p_valid = 1'b0;
      p_ready     = '0;
      chk("err_zero_cnt", rsp_err, 64'h1);
      // Counter must still be 0: exactly four grants before the cap
      q_valid = 8'h40;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("err_cnt6_grant", q_ready, 64'h40);
         tick();
      end
      #1;
      chk("err_cnt6_cap", q_ready, 64'h00);
      q_valid = '0;

      // Out-of-range index with NumReq = 5
      slv_p_valid5 = 1'b1;
      slv_p_id5    = 8'hE4;
      p_ready5     = '0;
      #1;
      chk("oor_ready", slv_p_ready5, 64'h1);
      chk("oor_no_valid", p_valid5, 64'h00);
      chk("oor_err_pre", rsp_err5, 64'h0);
      tick();
      chk("oor_err", rsp_err5, 64'h1);
      slv_p_id5 = 8'h80;
      #1;
      chk("n5_route_valid", p_valid5, 64'h10);
      chk("n5_route_ready", slv_p_ready5, 64'h0);
      slv_p_valid5 = 1'b0;
      tick();

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule

// File: doc/acc_req_arbiter.md
# acc_req_arbiter

Round-robin arbiter that shares one accelerator port among `NumReq` offloading cores. It sits in front of a single accelerator, or a single `acc_interconnect_intf` slave port, when several cores share it. On the request path it grants one master per cycle, extends the request ID with the master index, and registers the request. On the response path it routes each response back to its master by the index bits, and it caps in-flight requests per master with outstanding counters.

## Interface
- `NumReq`, 8: number of requesting masters (≥1).
- `AccAddrWidth`, 3: request address width, passed through unchanged.
- `DataWidth`, 32: request and response payload width.
- `InIdWidth`, 5: master-side ID width.
- `MaxOutstanding`, 4: maximum unanswered requests per master (≥1).
- `IdxWidth`, derived: `cf_math_pkg::idx_width(NumReq)`.
- `ExtIdWidth`, derived: `InIdWidth + IdxWidth`.
- `clk_i` in 1: clock. One clock only.
- `rst_ni` in 1: reset, synchronous, active-low.
- `mst_q_valid_i` in NumReq: per-master request valid.
- `mst_q_ready_o` out NumReq: per-master request ready.
- `mst_q_addr_i` in NumReq×AccAddrWidth: request address.
- `mst_q_id_i` in NumReq×InIdWidth: request ID.
- `mst_q_data_i` in NumReq×DataWidth: request payload.
- `mst_p_valid_o` out NumReq: response valid.
- `mst_p_ready_i` in NumReq: response ready.
- `mst_p_id_o` out InIdWidth: response ID, shared by all masters.
- `mst_p_data_o` out DataWidth: response payload, shared by all masters.
- `slv_q_valid_o` out 1, `slv_q_ready_i` in 1: request handshake to the accelerator.
- `slv_q_addr_o` out AccAddrWidth, `slv_q_id_o` out ExtIdWidth, `slv_q_data_o` out DataWidth: request fields to the accelerator.
- `slv_p_valid_i` in 1, `slv_p_ready_o` out 1: response handshake from the accelerator.
- `slv_p_id_i` in ExtIdWidth, `slv_p_data_i` in DataWidth: response fields from the accelerator.
- `rsp_err_o` out 1: sticky error flag. Set on a response with an out-of-range index or a response to a master with zero outstanding requests.

## Operation
- **Eligibility:** master k is eligible when `mst_q_valid_i[k]` is high and `cnt[k] < MaxOutstanding`.
- **Output register:** loads when `!slv_q_valid_o || slv_q_ready_i`. Only in that cycle is at most one `mst_q_ready_o[k]` high, for the granted master k.
- **Grant:** the first eligible master strictly after `rr_ptr`, scanning upward with wrap. `rr_ptr` updates to k only on a master handshake.
- **ID extension:** `slv_q_id_o = {k[IdxWidth-1:0], mst_q_id_i[k]}`. Address and data are copied unchanged.
- **Hold:** payload and valid stay stable while `slv_q_valid_o && !slv_q_ready_i`. There are no bubbles: a new grant can load in the same cycle the held request drains.
- **Response index:** `idx = slv_p_id_i[ExtIdWidth-1 -: IdxWidth]`.
- **Response demux (combinational):**
  - `mst_p_valid_o[idx] = slv_p_valid_i`; all other `mst_p_valid_o` bits are 0.
  - `slv_p_ready_o = mst_p_ready_i[idx]`.
  - `mst_p_id_o = slv_p_id_i[InIdWidth-1:0]`; `mst_p_data_o = slv_p_data_i`.
- **Out-of-range index** (`idx ≥ NumReq`): `slv_p_ready_o = 1`, the response is dropped, no master sees valid, and `rsp_err_o` is set.
- **Outstanding counters:** `cnt[k]` is `$clog2(MaxOutstanding+1)` bits wide.
  - Increments on a master-k request handshake.
  - Decrements on a response handshake with `idx == k`.
  - Both in the same cycle: unchanged.
  - Decrement at 0: saturates at 0 and sets `rsp_err_o`.
- **Reset:** all in-flight state is discarded. A late response after reset hits `cnt == 0` and sets `rsp_err_o`.

## Timing
- **Reset values:** `slv_q_valid_o` 0; `mst_q_ready_o` 0; `mst_p_valid_o` 0; `rsp_err_o` 0; all `cnt` 0; `rr_ptr = NumReq-1`, so master 0 wins first; `slv_q_*` payload 0.
- **Request latency:** a handshake at master k in cycle N gives `slv_q_valid_o` high in cycle N+1.
- **Request throughput:** one request per cycle while `slv_q_ready_i` stays high.
- **Response latency:** 0 cycles, purely combinational.
- **Ready dependencies:** `mst_q_ready_o` depends combinationally on `slv_q_ready_i`. `slv_p_ready_o` depends combinationally on `mst_p_ready_i` and `slv_p_id_i`.
- **Counter timing:** the counter is full (`cnt == MaxOutstanding`) one cycle after the handshake that fills it. A response arriving in that same cycle re-enables the master on the next cycle.
- **Fairness:** with all masters continuously eligible and `slv_q_ready_i` high, the grant order is 0,1,…,NumReq-1,0,…. No master waits more than NumReq-1 grants.

## Test plan
- **Round-robin order:** all 8 masters hold valid with IDs 0x00..0x07, `slv_q_ready_i = 1`. Slave sees ext-IDs `{0,0x00}`, `{1,0x01}`, …, `{7,0x07}`, then `{0,…}` again, one per cycle starting at cycle 1.
- **Backpressure:** master 3 sends addr 2, data 0xDEADBEEF; `slv_q_ready_i` is held low for 5 cycles. Slave payload stays stable, all `mst_q_ready_o` stay 0 during the stall, and the transfer completes on the first ready cycle.
- **Outstanding cap:** master 2 issues 4 requests with no responses. The 5th request is not granted and `mst_q_ready_o[2]` stays 0. One response with idx 2 arrives; the 5th request is granted the following cycle.
- **Response routing:** response ext-ID `{5,0x1A}`, data 0x1234. `mst_p_valid_o = 8'b0010_0000`, `mst_p_id_o = 0x1A`. `slv_p_ready_o` follows `mst_p_ready_i[5]`; other masters see no valid.
- **Errors:** a response to master 6 with `cnt[6] = 0` sets `rsp_err_o`, `cnt[6]` stays 0. With NumReq = 5, a response with idx 7 is accepted (`slv_p_ready_o = 1`), dropped, and sets `rsp_err_o`.
- **Reset mid-operation:** `rst_ni` is held low for 1 cycle while requests are held and counters are non-zero. Next cycle: all valids 0, `cnt` 0, `rr_ptr` restored so master 0 wins first, `rsp_err_o` cleared.
